// File: rtl/multi_run_detector.sv
// Per-channel Moore run/gap detector with saturating hit counters; z is registered state decode, 1-edge latency.
// No backpressure: every channel samples w on every rising edge; en low parks a channel in IDLE.
module multi_run_detector #(
    parameter int CH      = 4,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH-1:0]         en,
    input  logic [CH-1:0]         w,
    input  logic                  clr_cnt,
    output logic [CH-1:0]         z,
    output logic                  any_z,
    output logic [CH*CNT_W-1:0]   hit_cnt
);

    localparam int              CW          = $clog2(RUN_LEN);
    localparam logic [CW:0]     RUN_END     = (CW+1)'(RUN_LEN);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]   CNT_REENTRY = CW'(RUN_LEN - 1);
    localparam logic [CW:0]     INC_ONE     = (CW+1)'(1);
    localparam logic [CNT_W-1:0] HCNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HIT   = 3'd2,
        ST_GAP   = 3'd3,
        ST_PULSE = 3'd4
    } state_e;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_e             state_q, state_d;
        logic [CW-1:0]      cnt_q, cnt_d;
        logic [CW:0]        cnt_inc;
        logic               cnt_ok;
        logic               z_next;
        logic               z_rise;
        logic [CNT_W-1:0]   hcnt_q, hcnt_d;

        always_comb begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cnt_inc = {1'b0, cnt_q} + INC_ONE;
            // A COUNT state carrying an out-of-range run length is treated as corrupt.
            cnt_ok  = (cnt_q != '0) && ({1'b0, cnt_q} < RUN_END);
            if (en[i]) begin
                case (state_q)
                    ST_IDLE: begin
                        if (w[i]) begin
                            state_d = ST_COUNT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    ST_COUNT: begin
                        if (!cnt_ok) begin
                            state_d = ST_IDLE;
                        end else if (!w[i]) begin
                            state_d = ST_GAP;
                        end else if (cnt_inc == RUN_END) begin
                            state_d = ST_HIT;
                        end else begin
                            state_d = ST_COUNT;
                            cnt_d   = cnt_inc[CW-1:0];
                        end
                    end
                    ST_HIT: begin
                        state_d = w[i] ? ST_HIT : ST_GAP;
                    end
                    ST_GAP: begin
                        state_d = w[i] ? ST_PULSE : ST_IDLE;
                    end
                    ST_PULSE: begin
                        if (w[i]) begin
                            state_d = ST_COUNT;
                            cnt_d   = CNT_REENTRY;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        assign z[i]   = (state_q == ST_HIT) || (state_q == ST_PULSE);
        assign z_next = (state_d == ST_HIT) || (state_d == ST_PULSE);
        assign z_rise = z_next && !z[i];

        always_comb begin
            hcnt_d = hcnt_q;
            if (clr_cnt) begin
                hcnt_d = '0;
            end else if (z_rise && (hcnt_q != HCNT_MAX)) begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                hcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hcnt_q  <= hcnt_d;
            end
        end

        assign hit_cnt[i*CNT_W +: CNT_W] = hcnt_q;
    end

    assign any_z = |z;

endmodule

// File: tb/tb_multi_run_detector.sv
// Table-driven bench for multi_run_detector (CH=2, RUN_LEN=3, CNT_W=4) with an expectation queue.
module tb_multi_run_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] en;
    logic [1:0] w;
    logic       clr_cnt;
    logic [1:0] z;
    logic       any_z;
    logic [7:0] hit_cnt;

    multi_run_detector #(.CH(2), .RUN_LEN(3), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .w       (w),
        .clr_cnt (clr_cnt),
        .z       (z),
        .any_z   (any_z),
        .hit_cnt (hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [1:0] en;
        logic [1:0] w;
        logic       clr;
        logic [1:0] z;
        logic [3:0] hc0;
        logic [3:0] hc1;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   split;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
    endtask

    task automatic add(input logic [1:0] e, input logic [1:0] wv, input logic c,
                       input logic [1:0] ez, input int h0, input int h1);
        vec_t v;
        v.idx = tbl.size();
        v.en  = e;
        v.w   = wv;
        v.clr = c;
        v.z   = ez;
        v.hc0 = 4'(h0);
        v.hc1 = 4'(h1);
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        en      = v.en;
        w       = v.w;
        clr_cnt = v.clr;
        exp_q.push_back(v);
    endtask

    // Compare each posted expectation one step after the edge it belongs to.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("z", e.idx, 32'(z), 32'(e.z));
                chk("any_z", e.idx, 32'(any_z), 32'(|e.z));
                chk("hit_cnt", e.idx, 32'(hit_cnt), 32'({e.hc1, e.hc0}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    initial begin
        int h1;
        reset   = 1'b1;
        en      = 2'b11;
        w       = 2'b00;
        clr_cnt = 1'b0;

        // ch0: 1,1,1,1 then drop, clear counters
        add(2'b11, 2'b01, 0, 2'b00, 0, 0);
        add(2'b11, 2'b01, 0, 2'b00, 0, 0);
        add(2'b11, 2'b01, 0, 2'b01, 1, 0);
        add(2'b11, 2'b01, 0, 2'b01, 1, 0);
        add(2'b11, 2'b00, 1, 2'b00, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        // ch0: 1,0,1,1,1
        add(2'b11, 2'b01, 0, 2'b00, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        add(2'b11, 2'b01, 0, 2'b01, 1, 0);
        add(2'b11, 2'b01, 0, 2'b00, 1, 0);
        add(2'b11, 2'b01, 0, 2'b01, 2, 0);
        add(2'b11, 2'b00, 1, 2'b00, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        // ch0: 1,0,0,1 leaves COUNT cnt=1; two more 1s reach HIT
        add(2'b11, 2'b01, 0, 2'b00, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        add(2'b11, 2'b01, 0, 2'b00, 0, 0);
        add(2'b11, 2'b01, 0, 2'b00, 0, 0);
        add(2'b11, 2'b01, 0, 2'b01, 1, 0);
        // ch0 disabled for one edge while in HIT, then re-run
        add(2'b10, 2'b01, 0, 2'b00, 1, 0);
        add(2'b11, 2'b01, 0, 2'b00, 1, 0);
        add(2'b11, 2'b01, 0, 2'b00, 1, 0);
        add(2'b11, 2'b01, 0, 2'b01, 2, 0);
        // ch1: (1,0) x20 then 1, saturating at 15
        for (int p = 1; p <= 20; p++) begin
            h1 = (p - 1 > 15) ? 15 : p - 1;
            add(2'b11, 2'b10, 0, (p == 1) ? 2'b00 : 2'b10, 2, h1);
            add(2'b11, 2'b00, 0, 2'b00, 2, h1);
        end
        add(2'b11, 2'b10, 0, 2'b10, 2, 15);
        // clear coinciding with GAP->PULSE
        add(2'b11, 2'b00, 0, 2'b00, 2, 15);
        add(2'b11, 2'b10, 1, 2'b10, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        add(2'b11, 2'b10, 0, 2'b10, 0, 1);
        // bring both channels to HIT with hit_cnt=3
        add(2'b11, 2'b00, 1, 2'b00, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        add(2'b11, 2'b11, 0, 2'b00, 0, 0);
        add(2'b11, 2'b00, 0, 2'b00, 0, 0);
        add(2'b11, 2'b11, 0, 2'b11, 1, 1);
        add(2'b11, 2'b00, 0, 2'b00, 1, 1);
        add(2'b11, 2'b11, 0, 2'b11, 2, 2);
        add(2'b11, 2'b11, 0, 2'b00, 2, 2);
        add(2'b11, 2'b11, 0, 2'b11, 3, 3);
        split = tbl.size();
        // after mid-run reset
        add(2'b11, 2'b11, 0, 2'b00, 0, 0);
        add(2'b11, 2'b11, 0, 2'b00, 0, 0);
        add(2'b11, 2'b11, 0, 2'b11, 1, 1);

        #2;
        chk("rst_z", -1, 32'(z), 32'd0);
        chk("rst_any_z", -1, 32'(any_z), 32'd0);
        chk("rst_hit_cnt", -1, 32'(hit_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < split; k++) apply(tbl[k]);

        // asynchronous reset between edges while both channels are in HIT
        @(negedge clk);
        w     = 2'b00;
        reset = 1'b1;
        #1;
        chk("mid_rst_z", -2, 32'(z), 32'd0);
        chk("mid_rst_any_z", -2, 32'(any_z), 32'd0);
        chk("mid_rst_hit_cnt", -2, 32'(hit_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = split; k < tbl.size(); k++) apply(tbl[k]);

        repeat (2) @(negedge clk);
        chk("queue_drained", -3, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multi_run_detector.md
# multi_run_detector

Parametrised, multi-channel serial-pattern detector: the next generation of the single-input Moore run/gap detector FSM. Each of CH independent channels samples its input bit `w[i]` every clock, tracks a run of 1s, tolerates a single-0 gap, and drives a Moore output `z[i]`. Each channel also has a saturating hit counter. The block sits between the serial line samplers and the status/interrupt logic.

## Interface
- CH, 4, number of independent channels (>=1)
- RUN_LEN, 3, consecutive 1s needed to reach HIT (>=2)
- CNT_W, 8, width of each per-channel hit counter (>=1)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  CH  per-channel enable; low forces that channel to IDLE
- w  input  CH  serial data bit per channel, sampled at posedge clk
- clr_cnt  input  1  synchronous clear of all hit counters
- z  output  CH  per-channel detect, Moore decode of state register
- any_z  output  1  OR of z
- hit_cnt  output  CH*CNT_W  per-channel hit counters; channel i at [i*CNT_W +: CNT_W]

## Operation
- Per-channel state: IDLE, COUNT (run counter cnt in 1..RUN_LEN-1, width $clog2(RUN_LEN)), HIT, GAP, PULSE.
- z[i] = 1 in HIT or PULSE, else 0. It is decoded from flops only, with no combinational path from w.
- Transitions with en[i]=1:
  - IDLE: w=1 -> COUNT cnt=1 (HIT directly if RUN_LEN==1 is not allowed); w=0 -> IDLE.
  - COUNT: w=1 -> cnt+1, or HIT if cnt+1==RUN_LEN; w=0 -> GAP.
  - HIT: w=1 -> HIT; w=0 -> GAP.
  - GAP: w=1 -> PULSE; w=0 -> IDLE.
  - PULSE: w=1 -> COUNT cnt=RUN_LEN-1; w=0 -> GAP.
- With RUN_LEN=3, the transitions are exactly the six-state legacy detector:
  - IDLE=A, COUNT1=B, COUNT2=C, HIT=E, GAP=D, PULSE=F.
- en[i]=0: the next state is IDLE and cnt=0 regardless of w, and hit_cnt[i] holds.
- Unreachable or illegal encodings recover to IDLE on the next edge.
- hit_cnt[i] increments on the edge where z[i] goes 0 -> 1, i.e. COUNT->HIT or GAP->PULSE.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - HIT->HIT and PULSE->COUNT do not count.
- clr_cnt=1: all counters become 0 on the next edge. Clear wins over a simultaneous increment. clr_cnt does not affect channel FSMs.
- Channels are fully independent; no shared arbitration.

## Timing
- Reset (asynchronous assert, released synchronously by the integrator):
  - all channels go to IDLE, cnt=0, z=0, any_z=0, hit_cnt=0.
  - This takes effect immediately, without waiting for a clock edge.
- Reset asserted mid-run (HIT/PULSE): z drops in the same timestep and the counter value is lost.
- Latency: w sampled at edge k. z reflects the resulting state after edge k, so it is valid from edge k until edge k+1.
- Minimum detect latency from IDLE: RUN_LEN edges of w=1.
- Fastest pattern 1,0,1 from IDLE: z=1 after the 3rd edge, independent of RUN_LEN.
- any_z is combinational OR of registered z, with the same timing as z.
- hit_cnt updates on the same edge that z rises.

## Test plan
- CH=2, RUN_LEN=3, CNT_W=4, en=2'b11. After reset, ch0 w=1,1,1,1:
  - z[0] after each edge = 0,0,1,1; hit_cnt[0]=1; z[1]=0, hit_cnt[1]=0.
- ch0 w=1,0,1,1,1 from IDLE:
  - z[0] = 0,0,1,0,1 (IDLE→COUNT→GAP→PULSE→COUNT2→HIT); hit_cnt[0]=2.
- ch0 w=1,0,0,1: z[0] = 0,0,0,0; final state COUNT cnt=1; hit_cnt[0]=0.
- ch1 pattern 1,0 repeated 20 times, then 1:
  - hit_cnt[1] saturates at 15.
  - clr_cnt pulsed on the same edge as a GAP->PULSE transition -> hit_cnt[1]=0 afterwards, and z[1]=1 unaffected.
- ch0 in HIT, en[0] deasserted for one edge:
  - z[0]=0 after that edge, hit_cnt holds.
  - Re-enabled with w=1,1,1 -> z[0]=1 after the 3rd edge.
- Both channels in HIT with hit_cnt=3, reset asserted between edges:
  - z=0, any_z=0, hit_cnt=0 immediately, with no clock edge required.
  - After release, w=1,1,1 -> z=1 after the 3rd edge.
